// File: rtl/cic_decimate_pkg.sv
// cic_decimate_pkg: shared widths and rate clamp/shift helpers for the CIC I/Q decimator
package cic_decimate_pkg;

   function automatic int cic_width(int dw, int n, int max_rate);
      return dw + n * $clog2(max_rate);
   endfunction

   function automatic int rate_width(int max_rate);
      return $clog2(max_rate + 1);
   endfunction

   function automatic int shift_width(int n, int max_rate);
      return $clog2(n * $clog2(max_rate) + 1);
   endfunction

   function automatic int unsigned clamp_rate(int unsigned r, int unsigned max_rate);
      return (r == 0) ? 1 : (r > max_rate) ? max_rate : r;
   endfunction

   function automatic int unsigned rate_shift(int unsigned r, int unsigned n);
      int unsigned l;
      l = 0;
      for (int i = 0; i < 32; i++)
         if (((r - 1) >> i) != 0) l = i + 1;
      return n * l;
   endfunction

endpackage

// File: rtl/cic_decimate_chan.sv
// cic_decimate_chan: one CIC channel (integrators, combs, shift, optional rounding via CIC_DECIMATE_ROUND_EN, saturation)
module cic_decimate_chan import cic_decimate_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 4,
   parameter int MAX_RATE   = 128
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   flush_i,
   input  logic                                   integ_en_i,
   input  logic [N:0]                             en_i,
   input  logic [shift_width(N, MAX_RATE)-1:0]    shift_i,
   input  logic signed [DATA_WIDTH-1:0]           din_i,
   output logic signed [DATA_WIDTH-1:0]           dout_o
);

   localparam int W  = cic_width(DATA_WIDTH, N, MAX_RATE);
   localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic signed [W-1:0]          int_q [N];
   logic signed [W-1:0]          int_d [N];
   logic signed [W-1:0]          dly_q [N];
   logic signed [W-1:0]          dly_d [N];
   logic signed [W-1:0]          cmb_q [N];
   logic signed [W-1:0]          cmb_d [N];
   logic signed [DATA_WIDTH-1:0] out_q, out_d;
   logic signed [W-1:0]          s, x;
   logic signed [W:0]            sum, sh;
   logic [W-DATA_WIDTH+1:0]      hi;

   // integrator cascade feeds the combs with the freshly accumulated value, so R=1 is an exact identity
   always_comb begin
      s = W'(din_i);
      for (int k = 0; k < N; k++) begin
         s = s + int_q[k];
         int_d[k] = flush_i ? '0 : integ_en_i ? s : int_q[k];
      end
      x = s;
      for (int k = 0; k < N; k++) begin
         cmb_d[k] = flush_i ? '0 : en_i[k] ? x - dly_q[k] : cmb_q[k];
         dly_d[k] = flush_i ? '0 : en_i[k] ? x : dly_q[k];
         x = cmb_q[k];
      end
`ifdef CIC_DECIMATE_ROUND_EN
      sum = {cmb_q[N-1][W-1], cmb_q[N-1]} + ((shift_i == '0) ? '0 : ({{W{1'b0}}, 1'b1} << (shift_i - 1'b1)));
`else
      sum = {cmb_q[N-1][W-1], cmb_q[N-1]};
`endif
      sh = sum >>> shift_i;
      hi = sh[W:DATA_WIDTH-1];
      out_d = !en_i[N] ? out_q : (&hi || !(|hi)) ? sh[DATA_WIDTH-1:0] : sh[W] ? MIN_V : MAX_V;
   end

   // filter state and held output sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_q <= '{default: '0};
         dly_q <= '{default: '0};
         cmb_q <= '{default: '0};
         out_q <= '0;
      end else begin
         int_q <= int_d;
         dly_q <= dly_d;
         cmb_q <= cmb_d;
         out_q <= out_d;
      end
   end

   assign dout_o = out_q;

endmodule

// File: rtl/cic_decimate_iq.sv
// cic_decimate_iq: phase-aligned I/Q CIC decimator; rounding enabled by CIC_DECIMATE_ROUND_EN
module cic_decimate_iq import cic_decimate_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int N          = 4,
   parameter int MAX_RATE   = 128
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          rate_stb,
   input  logic [$clog2(MAX_RATE+1)-1:0] rate,
   input  logic                          strobe_in,
   input  logic [DATA_WIDTH-1:0]         in_itdata,
   input  logic [DATA_WIDTH-1:0]         in_qtdata,
   output logic                          strobe_out,
   output logic [DATA_WIDTH-1:0]         out_itdata,
   output logic [DATA_WIDTH-1:0]         out_qtdata
);

   localparam int RW = rate_width(MAX_RATE);
   localparam int SW = shift_width(N, MAX_RATE);

   logic [RW-1:0] r_q, r_d, cnt_q, cnt_d;
   logic [SW-1:0] sh_q, sh_d;
   logic [N:1]    v_q, v_d;
   logic          stb_q, stb_d;
   logic          acc, dec;
   logic [N:0]    en;

   // shared decimation counter, rate/shift latch and comb-stage valid pipeline
   always_comb begin
      acc   = strobe_in & ~rate_stb;
      dec   = acc & (cnt_q == r_q - 1'b1);
      r_d   = rate_stb ? RW'(clamp_rate(32'(rate), MAX_RATE)) : r_q;
      sh_d  = rate_stb ? SW'(rate_shift(clamp_rate(32'(rate), MAX_RATE), N)) : sh_q;
      cnt_d = (rate_stb | dec) ? '0 : cnt_q + RW'(acc);
      v_d   = rate_stb ? '0 : N'({v_q, dec});
      en    = rate_stb ? '0 : {v_q, dec};
      stb_d = ~rate_stb & v_q[N];
   end

   // control state; reset selects the largest ratio
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q   <= RW'(MAX_RATE);
         sh_q  <= SW'(rate_shift(MAX_RATE, N));
         cnt_q <= '0;
         v_q   <= '0;
         stb_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         v_q   <= v_d;
         stb_q <= stb_d;
      end
   end

   cic_decimate_chan #(.DATA_WIDTH(DATA_WIDTH), .N(N), .MAX_RATE(MAX_RATE)) u_i (
      .clk(clk), .reset_n(reset_n), .flush_i(rate_stb), .integ_en_i(acc), .en_i(en),
      .shift_i(sh_q), .din_i(in_itdata), .dout_o(out_itdata)
   );

   cic_decimate_chan #(.DATA_WIDTH(DATA_WIDTH), .N(N), .MAX_RATE(MAX_RATE)) u_q (
      .clk(clk), .reset_n(reset_n), .flush_i(rate_stb), .integ_en_i(acc), .en_i(en),
      .shift_i(sh_q), .din_i(in_qtdata), .dout_o(out_qtdata)
   );

   assign strobe_out = stb_q;

endmodule

// File: tb/tb_cic_decimate_iq.sv
// tb_cic_decimate_iq: directed vector table plus corner sequences for cic_decimate_iq
module tb_cic_decimate_iq;

   localparam int DW = 16;
   localparam int N  = 4;
   localparam int MR = 128;
   localparam int RW = $clog2(MR + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rate_stb = 1'b0;
   logic          strobe_in = 1'b0;
   logic [RW-1:0] rate = '0;
   logic [DW-1:0] in_i = '0, in_q = '0;
   logic          strobe_out;
   logic [DW-1:0] out_i, out_q;

   int     tests = 0, fails = 0, n_out = 0;
   longint last_i = 0, last_q = 0;
   logic   so = 1'b0;

   typedef struct {int r; int di; int dq; int n; int ei; int eq; int no;} vec_t;
   vec_t tbl [8];

   always #5 clk = ~clk;

   cic_decimate_iq #(.DATA_WIDTH(DW), .N(N), .MAX_RATE(MR)) dut (
      .clk(clk), .reset_n(reset_n), .rate_stb(rate_stb), .rate(rate),
      .strobe_in(strobe_in), .in_itdata(in_i), .in_qtdata(in_q),
      .strobe_out(strobe_out), .out_itdata(out_i), .out_qtdata(out_q)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic s, input int i, input int q, input logic rs, input int r);
      strobe_in = s;
      in_i = DW'(i);
      in_q = DW'(q);
      rate_stb = rs;
      rate = RW'(r);
      @(posedge clk);
      #1;
      strobe_in = 1'b0;
      rate_stb = 1'b0;
      so = strobe_out;
      if (strobe_out) begin
         n_out++;
         last_i = longint'($signed(out_i));
         last_q = longint'($signed(out_q));
      end
   endtask

   task automatic idle(input int k);
      for (int j = 0; j < k; j++) step(1'b0, 0, 0, 1'b0, 0);
   endtask

   initial begin
      longint exp_ri, exp_rq;
      tbl[0] = '{4,   1000,   -1000, 32,  1000,   -1000, 8};
      tbl[1] = '{128, -32768, 32767, 768, -32768, 32767, 6};
      tbl[2] = '{0,   123,    -45,   10,  123,    -45,   10};
      tbl[3] = '{200, 500,    -7,    768, 500,    -7,    6};
      tbl[4] = '{3,   256,    -256,  30,  81,     -81,   10};
      tbl[5] = '{5,   4096,   -4096, 40,  625,    -625,  8};
      tbl[6] = '{8,   32767,  -1,    64,  32767,  -1,    8};
      tbl[7] = '{6,   4096,   -4096, 48,  1296,   -1296, 8};
`ifdef CIC_DECIMATE_ROUND_EN
      exp_ri = 1;
      exp_rq = 0;
`else
      exp_ri = 0;
      exp_rq = -1;
`endif

      strobe_in = 1'b1;
      in_i = 16'd77;
      #12;
      chk("reset_strobe_out", longint'(strobe_out), 0);
      chk("reset_out_i", longint'($signed(out_i)), 0);
      chk("reset_out_q", longint'($signed(out_q)), 0);
      strobe_in = 1'b0;
      reset_n = 1'b1;
      idle(2);

      for (int t = 0; t < 8; t++) begin
         step(1'b0, 0, 0, 1'b1, tbl[t].r);
         n_out = 0;
         for (int k = 0; k < tbl[t].n; k++) step(1'b1, tbl[t].di, tbl[t].dq, 1'b0, 0);
         idle(N + 3);
         chk($sformatf("vec%0d_count", t), n_out, tbl[t].no);
         chk($sformatf("vec%0d_i", t), last_i, tbl[t].ei);
         chk($sformatf("vec%0d_q", t), last_q, tbl[t].eq);
      end

      step(1'b0, 0, 0, 1'b1, 2);
      n_out = 0;
      for (int k = 0; k < 16; k++) step(1'b1, k % 2, -(k % 2), 1'b0, 0);
      idle(N + 2);
      chk("round_count", n_out, 8);
      chk("round_i", last_i, exp_ri);
      chk("round_q", last_q, exp_rq);

      step(1'b0, 0, 0, 1'b1, 1);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, k, -k, 1'b0, 0);
         if (k < N) chk("ramp_quiet", longint'(so), 0);
         else begin
            chk("ramp_stb", longint'(so), 1);
            chk("ramp_i", last_i, k - N);
            chk("ramp_q", last_q, -(k - N));
         end
      end
      idle(N + 2);

      step(1'b0, 0, 0, 1'b1, 4);
      for (int k = 0; k < 10; k++) step(1'b1, 100, -100, 1'b0, 0);
      step(1'b1, 100, -100, 1'b1, 8);
      n_out = 0;
      for (int k = 1; k <= 56; k++) begin
         step(1'b1, 100, -100, 1'b0, 0);
         if (k == 8 + N) begin
            chk("flush_first_stb", longint'(so), 1);
            chk("flush_quiet", n_out, 1);
         end
      end
      idle(N + 2);
      chk("flush_count", n_out, 7);
      chk("flush_dc_i", last_i, 100);
      chk("flush_dc_q", last_q, -100);

      step(1'b0, 0, 0, 1'b1, 4);
      for (int k = 0; k < 34; k++) step(1'b1, 1000, -1000, 1'b0, 0);
      chk("pre_reset_i", longint'($signed(out_i)), 1000);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_i", longint'($signed(out_i)), 0);
      chk("async_reset_q", longint'($signed(out_q)), 0);
      chk("async_reset_stb", longint'(strobe_out), 0);
      @(negedge clk);
      reset_n = 1'b1;
      n_out = 0;
      for (int k = 0; k < 127; k++) step(1'b1, 5, 5, 1'b0, 0);
      idle(N + 2);
      chk("post_reset_quiet", n_out, 0);
      step(1'b1, 5, 5, 1'b0, 0);
      idle(N);
      chk("post_reset_full_r", longint'(so), 1);
      chk("post_reset_count", n_out, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cic_decimate_iq.md
CIC_DECIMATE_IQ -- requirements
Module: cic_decimate_iq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: I and Q sample width, two's complement.
REQ-002 SHALL have parameter N, default 4: integrator/comb stage count.
REQ-003 SHALL have parameter MAX_RATE, default 128: largest decimation ratio.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port rate_stb, input, 1: loads rate and flushes the filter.
REQ-007 SHALL have port rate, input, $clog2(MAX_RATE+1): decimation ratio.
REQ-008 SHALL have port strobe_in, input, 1: input sample valid.
REQ-009 SHALL have ports in_itdata and in_qtdata, input, DATA_WIDTH each: I and Q input samples.
REQ-010 SHALL have port strobe_out, output, 1: single-cycle output sample valid.
REQ-011 SHALL have ports out_itdata and out_qtdata, output, DATA_WIDTH each: I and Q decimated samples.

Function
REQ-012 SHALL use internal width W = DATA_WIDTH + N*$clog2(MAX_RATE), with wrap-around (modulo) integrator arithmetic.
REQ-013 SHALL update all N integrators of each channel only in cycles with strobe_in=1.
REQ-014 SHALL keep one shared decimation counter that counts strobe_in pulses 0..R-1 and wraps, keeping I and Q phase-aligned.
REQ-015 SHALL pass the last-integrator value into the comb chain on the strobe_in where the counter equals R-1.
REQ-016 SHALL register each comb stage (differential delay 1).
REQ-017 SHALL assert strobe_out for exactly one cycle, N+1 cycles after the decimating strobe_in.
REQ-018 SHALL right-shift the comb output by N*$clog2(R) to give unity gain for power-of-two R; for other R, gain SHALL be R^N / 2^(N*ceil(log2 R)).
REQ-019 SHALL saturate the shifted result to DATA_WIDTH signed range.
REQ-020 SHALL hold out_itdata and out_qtdata stable between strobe_out pulses.
REQ-021 On rate_stb=1, SHALL latch R = rate, clear the counter, integrators, combs and pipeline valid bits, and ignore any coincident strobe_in.
REQ-022 SHALL treat rate=0 as R=1 and rate>MAX_RATE as R=MAX_RATE.
REQ-023 With R=1, SHALL produce one output per input at latency N+1 cycles.
REQ-024 SHALL ignore strobe_in in the same cycle as an active reset_n.

Reset
REQ-025 While reset_n=0, SHALL asynchronously clear all integrators, combs and the counter, and drive strobe_out=0, out_itdata=0, out_qtdata=0.
REQ-026 SHALL set R=MAX_RATE after reset; a mid-operation reset SHALL discard all in-flight samples.

Configuration
REQ-027 With macro CIC_DECIMATE_ROUND_EN defined, SHALL add half an LSB of the shift (2^(shift-1)) before shifting (round half up); with shift=0, no offset SHALL be added.
REQ-028 Without CIC_DECIMATE_ROUND_EN, SHALL truncate (floor) with no adder; latency SHALL be identical in both builds.

Structure
REQ-029 SHALL place W, the rate width and the clamp/shift helper functions in package cic_decimate_pkg.
REQ-030 SHALL put the per-channel integrators, combs, shift, round and saturate logic in sub-module cic_decimate_chan, instantiated for I and Q.
REQ-031 SHALL keep the shared counter, rate register and strobe pipeline in the top level.

Verification
REQ-032 Reset, rate=4 (N=4), I=1000 and Q=-1000 on every strobe_in -> after settling, outputs exactly 1000/-1000, one strobe_out per 4 strobe_in.
REQ-033 rate=128, I=-32768 and Q=32767 constant -> outputs -32768/32767, no wrap, strobe_out every 128 inputs.
REQ-034 rate=1, I ramp 0,1,2,... -> out_itdata equals input delayed N+1 cycles, strobe_out every cycle.
REQ-035 Mid-stream rate_stb with rate=8 coincident with strobe_in -> that sample dropped, no strobe_out for 8 inputs plus N+1 cycles, then DC settles to the input value.
REQ-036 Assert reset_n=0 between decimation points -> outputs 0 immediately; the first output after release needs a full R inputs.
REQ-037 rate=2, I alternating 0,1 -> average 0.5: 1 with CIC_DECIMATE_ROUND_EN, 0 without.
